bcd_serial_addsub: RTL and testbench

Parametrised, digit-serial, signed BCD adder/subtractor: two DIGITS-digit sign-magnitude BCD operands in, one sign-magnitude BCD result out, with overflow and invalid-digit flags. One BCD digit is processed per clock. Negative differences get a second ten's-complement correction pass, so the result is always true magnitude plus sign. It is the multi-digit, handshaked successor to our 4-bit add/sub-to-BCD block and sits between operand registers and the display/BCD formatting path.

---
 rtl/bcd_serial_addsub.sv | 150 +++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial signed BCD adder/subtractor: one digit per clock, sign-magnitude in and out,
// with a ten's-complement fix-up pass for negative differences.
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  a_sign,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic                  b_sign,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  out_sign,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  overflow,
  output logic                  invalid
);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned W  = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b, r_out_bcd, w_res;
  logic [IW-1:0]   r_idx;
  logic            r_c, r_a_sign, r_eb, r_sub_mode, r_bad;
  logic            r_out_sign, r_ovf, r_inv;
  logic            w_in_bad, w_accept, w_last, w_carry, w_res_zero, w_eb;
  logic [3:0]      w_a_dig, w_b_dig, w_r_dig, w_opa, w_opb, w_dig;
  logic [4:0]      w_sum;

  always_comb begin
    w_in_bad = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (a_bcd[4*k +: 4] > 4'd9 || b_bcd[4*k +: 4] > 4'd9) w_in_bad = 1'b1;
    end
  end

  assign w_eb     = b_sign ^ sub;
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_idx == IW'(DIGITS - 1));

  // FIX reuses the digit adder with operand A forced to 0 and B taken from the raw result
  always_comb begin
    w_a_dig = r_a[r_idx*4 +: 4];
    w_b_dig = r_b[r_idx*4 +: 4];
    w_r_dig = r_out_bcd[r_idx*4 +: 4];
    if (r_state == FIX) begin
      w_opa = 4'd0;
      w_opb = 4'd9 - w_r_dig;
    end else begin
      w_opa = w_a_dig;
      w_opb = r_sub_mode ? (4'd9 - w_b_dig) : w_b_dig;
    end
    w_sum   = {1'b0, w_opa} + {1'b0, w_opb} + {4'b0, r_c};
    w_carry = (w_sum > 5'd9);
    w_dig   = w_carry ? (w_sum[3:0] - 4'd10) : w_sum[3:0];
    w_res   = r_out_bcd;
    w_res[r_idx*4 +: 4] = w_dig;
    w_res_zero = (w_res == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (r_bad)       w_next = DONE;
        else if (w_last) w_next = (r_sub_mode && !w_carry) ? FIX : DONE;
      end
      FIX: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = w_accept ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // An invalid operand still spends one RUN cycle so that done appears one cycle after start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_idx <= '0; r_c <= 1'b0;
      r_a_sign <= 1'b0; r_eb <= 1'b0; r_sub_mode <= 1'b0; r_bad <= 1'b0;
      r_out_bcd <= '0; r_out_sign <= 1'b0; r_ovf <= 1'b0; r_inv <= 1'b0;
    end else if (w_accept) begin
      r_a        <= a_bcd;
      r_b        <= b_bcd;
      r_a_sign   <= a_sign;
      r_eb       <= w_eb;
      r_sub_mode <= (a_sign != w_eb);
      r_c        <= (a_sign != w_eb);
      r_bad      <= w_in_bad;
      r_idx      <= '0;
      r_out_bcd  <= '0;
      r_out_sign <= 1'b0;
      r_ovf      <= 1'b0;
      r_inv      <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (r_bad) begin
            r_inv <= 1'b1;
          end else begin
            r_out_bcd <= w_res;
            r_c       <= w_carry;
            r_idx     <= r_idx + 1'b1;
            if (w_last) begin
              r_idx <= '0;
              if (!r_sub_mode) begin
                r_ovf      <= w_carry;
                r_out_sign <= r_a_sign & ~w_res_zero;
              end else if (w_carry) begin
                r_out_sign <= r_a_sign & ~w_res_zero;
              end else begin
                r_out_sign <= r_eb;
                r_c        <= 1'b1;
              end
            end
          end
        end
        FIX: begin
          r_out_bcd <= w_res;
          r_c       <= w_carry;
          r_idx     <= w_last ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_bcd  = r_out_bcd;
  assign out_sign = r_out_sign;
  assign overflow = r_ovf;
  assign invalid  = r_inv;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: directed table at DIGITS=4, corner sequences, and random
// DIGITS=1/8 regression against a decimal integer model.
module tb_bcd_serial_addsub;
  logic clk = 1'b0, rst = 1'b1, st = 1'b0;
  logic sub_i = 1'b0, as_i = 1'b0, bs_i = 1'b0;
  logic [31:0] a_bus = '0, b_bus = '0;
  int sel = 4;
  int n_pass = 0, n_total = 0;

  logic busy1, done1, sign1, ovf1, inv1; logic [3:0]  bcd1;
  logic busy4, done4, sign4, ovf4, inv4; logic [15:0] bcd4;
  logic busy8, done8, sign8, ovf8, inv8; logic [31:0] bcd8;
  logic o_busy, o_done, o_sign, o_ovf, o_inv; logic [31:0] o_bcd;
  logic st1, st4, st8;

  assign st1 = st && (sel == 1);
  assign st4 = st && (sel == 4);
  assign st8 = st && (sel == 8);

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(1)) u_d1 (
    .clk(clk), .rst(rst), .start(st1), .sub(sub_i), .a_sign(as_i), .a_bcd(a_bus[3:0]),
    .b_sign(bs_i), .b_bcd(b_bus[3:0]), .busy(busy1), .done(done1), .out_sign(sign1),
    .out_bcd(bcd1), .overflow(ovf1), .invalid(inv1));
  bcd_serial_addsub #(.DIGITS(4)) u_d4 (
    .clk(clk), .rst(rst), .start(st4), .sub(sub_i), .a_sign(as_i), .a_bcd(a_bus[15:0]),
    .b_sign(bs_i), .b_bcd(b_bus[15:0]), .busy(busy4), .done(done4), .out_sign(sign4),
    .out_bcd(bcd4), .overflow(ovf4), .invalid(inv4));
  bcd_serial_addsub #(.DIGITS(8)) u_d8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub_i), .a_sign(as_i), .a_bcd(a_bus),
    .b_sign(bs_i), .b_bcd(b_bus), .busy(busy8), .done(done8), .out_sign(sign8),
    .out_bcd(bcd8), .overflow(ovf8), .invalid(inv8));

  always_comb begin
    o_busy = busy4; o_done = done4; o_sign = sign4; o_ovf = ovf4; o_inv = inv4;
    o_bcd  = {16'd0, bcd4};
    if (sel == 1) begin
      o_busy = busy1; o_done = done1; o_sign = sign1; o_ovf = ovf1; o_inv = inv1;
      o_bcd  = {28'd0, bcd1};
    end else if (sel == 8) begin
      o_busy = busy8; o_done = done8; o_sign = sign8; o_ovf = ovf8; o_inv = inv8;
      o_bcd  = bcd8;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (DIGITS=%0d): got %0h expected %0h", nm, sel, act, exp);
  endtask

  // Issue one request; returns at #1 after the accepting edge.
  task automatic issue(input int s, input logic sb, input logic as, input logic [31:0] a,
                       input logic bs, input logic [31:0] b);
    sel = s; sub_i = sb; as_i = as; a_bus = a; bs_i = bs; b_bus = b;
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    check("done_low_after_accept", o_done, 1'b0);
  endtask

  task automatic wait_done(input int pre, output int lat);
    lat = pre;
    while (lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (o_done) break;
    end
  endtask

  function automatic void model(input int nd, input logic sb, input logic as, input logic [31:0] a,
                                input logic bs, input logic [31:0] b, output logic es,
                                output logic [31:0] ebcd, output logic eov, output logic einv,
                                output int elat);
    longint av = 0, bv = 0, r, mag, lim = 1;
    logic bad = 1'b0;
    logic [3:0] da, db;
    for (int i = nd - 1; i >= 0; i--) begin
      da = a[4*i +: 4]; db = b[4*i +: 4];
      if (da > 9 || db > 9) bad = 1'b1;
      av = av * 10 + longint'(da);
      bv = bv * 10 + longint'(db);
      lim = lim * 10;
    end
    ebcd = '0;
    if (bad) begin
      es = 1'b0; eov = 1'b0; einv = 1'b1; elat = 1;
      return;
    end
    einv = 1'b0;
    r    = (as ? -av : av) + ((bs ^ sb) ? -bv : bv);
    mag  = (r < 0) ? -r : r;
    eov  = (mag >= lim);
    mag  = mag % lim;
    es   = (r < 0) && (mag != 0);
    for (int i = 0; i < nd; i++) begin
      ebcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    elat = ((as != (bs ^ sb)) && (av < bv)) ? 2 * nd : nd;
  endfunction

  function automatic logic [31:0] rand_bcd(input int nd);
    logic [31:0] v = '0;
    for (int i = 0; i < nd; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  typedef struct {
    logic sb; logic as; logic [31:0] a; logic bs; logic [31:0] b;
    logic es; logic [31:0] eb; logic eov; logic einv; int lat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int lat;
    logic es, eov, einv, b2b, saw;
    logic [31:0] a, b, ebcd;
    int elat;
    logic sb, as, bs;

    tbl[0]  = '{1'b0, 1'b0, 32'h1234, 1'b0, 32'h5678, 1'b0, 32'h6912, 1'b0, 1'b0, 4};
    tbl[1]  = '{1'b1, 1'b0, 32'h0123, 1'b0, 32'h0456, 1'b1, 32'h0333, 1'b0, 1'b0, 8};
    tbl[2]  = '{1'b0, 1'b0, 32'h9999, 1'b0, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 4};
    tbl[3]  = '{1'b1, 1'b1, 32'h0007, 1'b0, 32'h0007, 1'b1, 32'h0014, 1'b0, 1'b0, 4};
    tbl[4]  = '{1'b0, 1'b1, 32'h0500, 1'b0, 32'h0500, 1'b0, 32'h0000, 1'b0, 1'b0, 4};
    tbl[5]  = '{1'b1, 1'b0, 32'h0500, 1'b0, 32'h0499, 1'b0, 32'h0001, 1'b0, 1'b0, 4};
    tbl[6]  = '{1'b0, 1'b0, 32'h12A4, 1'b0, 32'h0001, 1'b0, 32'h0000, 1'b0, 1'b1, 1};
    tbl[7]  = '{1'b0, 1'b0, 32'h0001, 1'b0, 32'h0002, 1'b0, 32'h0003, 1'b0, 1'b0, 4};
    tbl[8]  = '{1'b1, 1'b1, 32'h0003, 1'b1, 32'h0010, 1'b0, 32'h0007, 1'b0, 1'b0, 8};
    tbl[9]  = '{1'b0, 1'b1, 32'h9999, 1'b1, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 4};
    tbl[10] = '{1'b1, 1'b0, 32'h0000, 1'b0, 32'h0000, 1'b0, 32'h0000, 1'b0, 1'b0, 4};
    tbl[11] = '{1'b0, 1'b0, 32'h0001, 1'b0, 32'hF000, 1'b0, 32'h0000, 1'b0, 1'b1, 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    foreach (tbl[i]) begin end
    for (int s = 1; s <= 8; s = s * 2) begin
      if (s == 2) continue;
      sel = s; #0;
      check("reset_busy", o_busy, 1'b0);
      check("reset_done", o_done, 1'b0);
      check("reset_bcd", o_bcd, 32'd0);
      check("reset_flags", {o_sign, o_ovf, o_inv}, 3'b000);
    end

    // directed table at DIGITS=4
    for (int i = 0; i < 12; i++) begin
      issue(4, tbl[i].sb, tbl[i].as, tbl[i].a, tbl[i].bs, tbl[i].b);
      if (!tbl[i].einv) check($sformatf("t%0d_busy", i), o_busy, 1'b1);
      wait_done(0, lat);
      check($sformatf("t%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("t%0d_bcd", i), o_bcd, tbl[i].eb);
      check($sformatf("t%0d_sign", i), o_sign, tbl[i].es);
      check($sformatf("t%0d_ovf", i), o_ovf, tbl[i].eov);
      check($sformatf("t%0d_inv", i), o_inv, tbl[i].einv);
      check($sformatf("t%0d_busy_done", i), o_busy, 1'b0);
      @(posedge clk); #1;
      check($sformatf("t%0d_done_pulse", i), o_done, 1'b0);
    end

    // start during RUN is ignored
    issue(4, 1'b0, 1'b0, 32'h1234, 1'b0, 32'h5678);
    @(posedge clk); #1;
    st = 1'b1; a_bus = 32'h9999; sub_i = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    wait_done(2, lat);
    check("ign_latency", lat, 4);
    check("ign_bcd", o_bcd, 32'h6912);
    check("ign_sign", o_sign, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("hold_bcd", o_bcd, 32'h6912);
    check("hold_done", o_done, 1'b0);

    // reset mid-run, with a start on the reset edge
    issue(4, 1'b1, 1'b0, 32'h0123, 1'b0, 32'h0456);
    @(posedge clk); #1;
    rst = 1'b1; st = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; st = 1'b0;
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_bcd", o_bcd, 32'd0);
    check("rst_flags", {o_sign, o_ovf, o_inv}, 3'b000);
    saw = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (o_done || o_busy) saw = 1'b1; end
    check("rst_no_done", saw, 1'b0);

    // random regression at DIGITS=1 and DIGITS=8, with back-to-back starts in DONE
    for (int s = 1; s <= 8; s = s + 7) begin
      b2b = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (!b2b) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        sb = 1'($urandom); as = 1'($urandom); bs = 1'($urandom);
        a = rand_bcd(s);
        b = ($urandom_range(0, 7) == 0) ? a : rand_bcd(s);
        model(s, sb, as, a, bs, b, es, ebcd, eov, einv, elat);
        issue(s, sb, as, a, bs, b);
        wait_done(0, lat);
        check($sformatf("r%0d_latency", k), lat, elat);
        check($sformatf("r%0d_bcd a=%0h b=%0h", k, a, b), o_bcd, ebcd);
        check($sformatf("r%0d_sign", k), o_sign, es);
        check($sformatf("r%0d_ovf", k), o_ovf, eov);
        check($sformatf("r%0d_inv", k), o_inv, einv);
        b2b = 1'($urandom);
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
